// File: rtl/fastram_cycle_ctrl.sv
// Fast RAM cycle controller: arbitrates the SRAM between the 68K bus and the aux
// (Pi-side DMA) port and produces registered SRAM strobes, mux select and DTACK.
module fastram_cycle_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       _RST,
  input  logic       _AS,
  input  logic       _UDS,
  input  logic       _LDS,
  input  logic       RW,
  input  logic       ramce,
  input  logic       aux_req,
  input  logic       aux_rw,
  input  logic [1:0] aux_be,
  output logic       aux_ack,
  output logic       ram_sel,
  output logic       ram_ce_n,
  output logic       ram_oe_n,
  output logic [1:0] ram_we_n,
  output logic       dtack
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_M_ACCESS = 3'd1;
  localparam logic [2:0] S_M_HOLD   = 3'd2;
  localparam logic [2:0] S_A_ACCESS = 3'd3;
  localparam logic [2:0] S_A_DONE   = 3'd4;

  localparam logic [2:0] W_LOAD = 3'(WAIT_CYCLES);

  logic       r_as_meta, r_as_s;
  logic       r_uds_meta, r_uds_s;
  logic       r_lds_meta, r_lds_s;

  logic [2:0] r_state, w_state_nx;
  logic [2:0] r_cnt, w_cnt_nx;
  logic       r_last_aux, w_last_aux_nx;
  logic       r_m_rw, w_m_rw_nx;
  logic       r_wr_armed, w_wr_armed_nx;

  logic       r_aux_ack, w_aux_ack_nx;
  logic       r_ram_sel, w_ram_sel_nx;
  logic       r_ce_n, w_ce_n_nx;
  logic       r_oe_n, w_oe_n_nx;
  logic [1:0] r_we_n, w_we_n_nx;
  logic       r_dtack, w_dtack_nx;

  logic       w_m_req;
  logic       w_grant_m;

  // Bus strobes are asynchronous to CLK; idle (high) is the reset value.
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      r_as_meta  <= 1'b1;
      r_as_s     <= 1'b1;
      r_uds_meta <= 1'b1;
      r_uds_s    <= 1'b1;
      r_lds_meta <= 1'b1;
      r_lds_s    <= 1'b1;
    end else begin
      r_as_meta  <= _AS;
      r_as_s     <= r_as_meta;
      r_uds_meta <= _UDS;
      r_uds_s    <= r_uds_meta;
      r_lds_meta <= _LDS;
      r_lds_s    <= r_lds_meta;
    end
  end

  assign w_m_req   = !r_as_s && ramce;
  // Round-robin: the 68K wins a tie only when the aux port had the last grant.
  assign w_grant_m = w_m_req && (!aux_req || r_last_aux);

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_last_aux_nx = r_last_aux;
    w_m_rw_nx     = r_m_rw;
    w_wr_armed_nx = r_wr_armed;
    w_aux_ack_nx  = 1'b0;
    w_ram_sel_nx  = r_ram_sel;
    w_ce_n_nx     = 1'b1;
    w_oe_n_nx     = 1'b1;
    w_we_n_nx     = 2'b11;
    w_dtack_nx    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_grant_m) begin
          w_state_nx    = S_M_ACCESS;
          w_cnt_nx      = W_LOAD;
          w_last_aux_nx = 1'b0;
          w_m_rw_nx     = RW;
          w_wr_armed_nx = 1'b0;
          w_ram_sel_nx  = 1'b0;
          w_ce_n_nx     = 1'b0;
          w_oe_n_nx     = !RW;
        end else if (aux_req) begin
          w_state_nx    = S_A_ACCESS;
          w_cnt_nx      = W_LOAD;
          w_last_aux_nx = 1'b1;
          w_ram_sel_nx  = 1'b1;
          w_ce_n_nx     = 1'b0;
          w_oe_n_nx     = !aux_rw;
          w_we_n_nx     = aux_rw ? 2'b11 : ~aux_be;
        end
      end

      S_M_ACCESS: begin
        if (r_as_s) begin
          // Aborted bus cycle: drop everything, never acknowledge.
          w_state_nx    = S_IDLE;
          w_cnt_nx      = 3'd0;
          w_wr_armed_nx = 1'b0;
        end else begin
          w_ce_n_nx = 1'b0;
          w_oe_n_nx = !r_m_rw;
          if (r_m_rw || r_wr_armed) begin
            if (r_cnt <= 3'd1) begin
              w_state_nx    = S_M_HOLD;
              w_cnt_nx      = 3'd0;
              w_dtack_nx    = 1'b1;
              w_wr_armed_nx = 1'b0;
            end else begin
              w_cnt_nx  = r_cnt - 3'd1;
              w_we_n_nx = r_m_rw ? 2'b11 : {r_uds_s, r_lds_s};
            end
          end else if (!r_uds_s || !r_lds_s) begin
            // First data strobe opens the write window; counting starts next CLK.
            w_wr_armed_nx = 1'b1;
            w_we_n_nx     = {r_uds_s, r_lds_s};
          end
        end
      end

      S_M_HOLD: begin
        if (r_as_s) begin
          w_state_nx = S_IDLE;
        end else begin
          w_ce_n_nx  = 1'b0;
          w_oe_n_nx  = !r_m_rw;
          w_dtack_nx = 1'b1;
        end
      end

      S_A_ACCESS: begin
        if (r_cnt <= 3'd1) begin
          w_state_nx   = S_A_DONE;
          w_cnt_nx     = 3'd0;
          w_aux_ack_nx = 1'b1;
        end else begin
          w_cnt_nx  = r_cnt - 3'd1;
          w_ce_n_nx = 1'b0;
          w_oe_n_nx = !aux_rw;
          w_we_n_nx = aux_rw ? 2'b11 : ~aux_be;
        end
      end

      S_A_DONE: begin
        w_state_nx   = S_IDLE;
        w_ram_sel_nx = 1'b0;
      end

      default: begin
        w_state_nx   = S_IDLE;
        w_cnt_nx     = 3'd0;
        w_ram_sel_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_last_aux <= 1'b1;
      r_m_rw     <= 1'b1;
      r_wr_armed <= 1'b0;
      r_aux_ack  <= 1'b0;
      r_ram_sel  <= 1'b0;
      r_ce_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_we_n     <= 2'b11;
      r_dtack    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_last_aux <= w_last_aux_nx;
      r_m_rw     <= w_m_rw_nx;
      r_wr_armed <= w_wr_armed_nx;
      r_aux_ack  <= w_aux_ack_nx;
      r_ram_sel  <= w_ram_sel_nx;
      r_ce_n     <= w_ce_n_nx;
      r_oe_n     <= w_oe_n_nx;
      r_we_n     <= w_we_n_nx;
      r_dtack    <= w_dtack_nx;
    end
  end

  assign aux_ack  = r_aux_ack;
  assign ram_sel  = r_ram_sel;
  assign ram_ce_n = r_ce_n;
  assign ram_oe_n = r_oe_n;
  assign ram_we_n = r_we_n;
  assign dtack    = r_dtack;

endmodule

// File: tb/tb_fastram_cycle_ctrl.sv
// Table-driven bench for fastram_cycle_ctrl: one row per CLK, plus a hand-written
// asynchronous-reset sequence.
module tb_fastram_cycle_ctrl;

  logic       CLK;
  logic       rst_n;
  logic       as_n, uds_n, lds_n, rw, ramce;
  logic       aux_req, aux_rw;
  logic [1:0] aux_be;
  logic       aux_ack, ram_sel, ram_ce_n, ram_oe_n, dtack;
  logic [1:0] ram_we_n;

  fastram_cycle_ctrl #(.WAIT_CYCLES(2)) dut (
    .CLK      (CLK),
    ._RST     (rst_n),
    ._AS      (as_n),
    ._UDS     (uds_n),
    ._LDS     (lds_n),
    .RW       (rw),
    .ramce    (ramce),
    .aux_req  (aux_req),
    .aux_rw   (aux_rw),
    .aux_be   (aux_be),
    .aux_ack  (aux_ack),
    .ram_sel  (ram_sel),
    .ram_ce_n (ram_ce_n),
    .ram_oe_n (ram_oe_n),
    .ram_we_n (ram_we_n),
    .dtack    (dtack)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Observed outputs: {ce_n, oe_n, we_n[1:0], dtack, aux_ack, ram_sel}
  logic [6:0] got;
  assign got = {ram_ce_n, ram_oe_n, ram_we_n, dtack, aux_ack, ram_sel};

  localparam logic [6:0] O_IDLE  = 7'b1_1_11_0_0_0;
  localparam logic [6:0] O_MRD   = 7'b0_0_11_0_0_0;
  localparam logic [6:0] O_MRD_H = 7'b0_0_11_1_0_0;
  localparam logic [6:0] O_MWR   = 7'b0_1_11_0_0_0;
  localparam logic [6:0] O_MWR_L = 7'b0_1_10_0_0_0;
  localparam logic [6:0] O_MWR_H = 7'b0_1_11_1_0_0;
  localparam logic [6:0] O_ARD   = 7'b0_0_11_0_0_1;
  localparam logic [6:0] O_AW01  = 7'b0_1_10_0_0_1;
  localparam logic [6:0] O_AW11  = 7'b0_1_00_0_0_1;
  localparam logic [6:0] O_ADONE = 7'b1_1_11_0_1_1;

  // Inputs: {as_n, uds_n, lds_n, rw, ramce, aux_req, aux_rw, aux_be[1:0]}
  localparam logic [8:0] I_QUIET = 9'b111_1_0_0_1_11;
  localparam logic [8:0] I_RD    = 9'b000_1_1_0_1_11;
  localparam logic [8:0] I_RD_AW = 9'b000_1_1_1_0_01;
  localparam logic [8:0] I_AW    = 9'b111_1_0_1_0_01;
  localparam logic [8:0] I_W_AS  = 9'b011_0_1_0_1_11;
  localparam logic [8:0] I_W_LDS = 9'b010_0_1_0_1_11;
  localparam logic [8:0] I_AR    = 9'b111_1_0_1_1_11;
  localparam logic [8:0] I_RD_AR = 9'b000_1_1_1_1_11;
  localparam logic [8:0] I_NOCE  = 9'b000_1_0_0_1_11;
  localparam logic [8:0] I_AW11  = 9'b111_1_0_1_0_11;

  typedef struct packed {
    logic [8:0] in;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic [8:0] in, input logic [6:0] exp);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [8:0] in);
    {as_n, uds_n, lds_n, rw, ramce, aux_req, aux_rw, aux_be} = in;
  endtask

  task automatic chk(input string name, input logic [6:0] g, input logic [6:0] w);
    checks++;
    if (g !== w) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, g, w);
    end else begin
      $display("ok   %s out=%b", name, g);
    end
  endtask

  task automatic chk_invariants(input int row);
    checks++;
    if ((dtack && aux_ack) || (!ram_oe_n && ram_we_n != 2'b11)) begin
      errors++;
      $display("FAIL invariant row%0d dtack=%b ack=%b oe_n=%b we_n=%b want exclusive",
               row, dtack, aux_ack, ram_oe_n, ram_we_n);
    end
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0;
    drive(I_QUIET);

    // Simultaneous requests just after reset: 68K first, then aux write be=01
    add(I_RD, O_IDLE);     add(I_RD, O_IDLE);
    add(I_RD_AW, O_MRD);   add(I_RD_AW, O_MRD);   add(I_RD_AW, O_MRD_H);
    add(I_AW, O_MRD_H);    add(I_AW, O_MRD_H);    add(I_AW, O_IDLE);
    add(I_AW, O_AW01);     add(I_AW, O_AW01);     add(I_AW, O_ADONE);
    add(I_QUIET, O_IDLE);  add(I_QUIET, O_IDLE);
    // 68K read: dtack two CLKs after entry, release one CLK after as_s high
    add(I_RD, O_IDLE);     add(I_RD, O_IDLE);     add(I_RD, O_MRD);
    add(I_RD, O_MRD);      add(I_RD, O_MRD_H);    add(I_RD, O_MRD_H);
    add(I_QUIET, O_MRD_H); add(I_QUIET, O_MRD_H); add(I_QUIET, O_IDLE);
    // 68K lower-byte write, _LDS three CLKs after _AS
    add(I_W_AS, O_IDLE);   add(I_W_AS, O_IDLE);   add(I_W_AS, O_MWR);
    add(I_W_LDS, O_MWR);   add(I_W_LDS, O_MWR);   add(I_W_LDS, O_MWR_L);
    add(I_W_LDS, O_MWR_L); add(I_W_LDS, O_MWR_H);
    add(I_QUIET, O_MWR_H); add(I_QUIET, O_MWR_H); add(I_QUIET, O_IDLE);
    // 68K cycle arriving during an aux read waits for aux_ack
    add(I_AR, O_ARD);      add(I_RD_AR, O_ARD);   add(I_RD_AR, O_ADONE);
    add(I_RD, O_IDLE);     add(I_RD, O_MRD);      add(I_RD, O_MRD);
    add(I_RD, O_MRD_H);    add(I_QUIET, O_MRD_H); add(I_QUIET, O_MRD_H);
    add(I_QUIET, O_IDLE);
    // Write aborted before any data strobe
    add(I_W_AS, O_IDLE);   add(I_W_AS, O_IDLE);   add(I_W_AS, O_MWR);
    add(I_QUIET, O_MWR);   add(I_QUIET, O_MWR);   add(I_QUIET, O_IDLE);
    add(I_QUIET, O_IDLE);
    // Tie after a 68K grant: aux wins this time
    add(I_RD, O_IDLE);     add(I_RD, O_IDLE);     add(I_RD_AR, O_ARD);
    add(I_RD_AR, O_ARD);   add(I_RD_AR, O_ADONE); add(I_RD, O_IDLE);
    add(I_RD, O_MRD);      add(I_RD, O_MRD);      add(I_RD, O_MRD_H);
    add(I_QUIET, O_MRD_H); add(I_QUIET, O_MRD_H); add(I_QUIET, O_IDLE);
    // _AS low without ramce is not a RAM cycle
    add(I_NOCE, O_IDLE);   add(I_NOCE, O_IDLE);   add(I_NOCE, O_IDLE);
    add(I_NOCE, O_IDLE);   add(I_QUIET, O_IDLE);  add(I_QUIET, O_IDLE);

    repeat (3) @(posedge CLK);
    #1 chk("reset_state", got, O_IDLE);
    @(negedge CLK);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      drive(vecs[i].in);
      @(posedge CLK);
      #1;
      chk($sformatf("row%0d in=%b", i, vecs[i].in), got, vecs[i].exp);
      chk_invariants(i);
    end

    // Asynchronous reset while a read sits in M_HOLD
    @(negedge CLK);
    drive(I_RD);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge CLK);
      #1;
      if (dtack) seen = 1'b1;
    end
    chk("rst_pre_hold", got, O_MRD_H);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_release", got, O_IDLE);
    @(negedge CLK);
    drive(I_QUIET);
    @(posedge CLK);
    #1 chk("rst_held", got, O_IDLE);
    @(negedge CLK);
    rst_n = 1'b1;
    drive(I_AW11);
    @(posedge CLK);
    #1 chk("rst_aux_grant", got, O_AW11);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge CLK);
      #1;
      if (aux_ack) seen = 1'b1;
    end
    chk("rst_aux_ack", got, O_ADONE);
    @(negedge CLK);
    drive(I_QUIET);
    @(posedge CLK);
    #1 chk("rst_aux_back_idle", got, O_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
